// File: rtl/text_pkg.sv
// Shared character codes, FSM state type and cursor operations for the text writer.
package text_pkg;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_FF    = 8'h0C;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_INC     = 3'd1,
        OP_NEWLINE = 3'd2,
        OP_CR      = 3'd3,
        OP_HOME    = 3'd4,
        OP_DEC     = 3'd5
    } cursor_op_e;

endpackage

// File: rtl/text_cursor.sv
// Row/column cursor registers with wrap-around increment, newline, home and
// decrement operations, plus the combinational linear cell address.
module text_cursor
    import text_pkg::*;
#(
    parameter int addr_width = 7,
    parameter int COLS       = 16,
    parameter int ROWS       = 5,
    parameter int ROW_W      = $clog2(ROWS),
    parameter int COL_W      = $clog2(COLS)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  cursor_op_e            op,
    output logic [ROW_W-1:0]      row,
    output logic [COL_W-1:0]      col,
    output logic [addr_width-1:0] addr
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [ROW_W-1:0] row_d;
    logic [COL_W-1:0] col_d;
    logic [ROW_W-1:0] row_next;

    // Next row with wrap back to the top; there is no scrolling.
    assign row_next = (row == ROW_LAST) ? '0 : row + ROW_W'(1);

    always_comb begin
        row_d = row;
        col_d = col;
        case (op)
            OP_INC: begin
                if (col == COL_LAST) begin
                    col_d = '0;
                    row_d = row_next;
                end else begin
                    col_d = col + COL_W'(1);
                end
            end
            OP_NEWLINE: begin
                col_d = '0;
                row_d = row_next;
            end
            OP_CR: begin
                col_d = '0;
            end
            OP_HOME: begin
                col_d = '0;
                row_d = '0;
            end
            OP_DEC: begin
                if (col != '0) begin
                    col_d = col - COL_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row <= '0;
            col <= '0;
        end else begin
            row <= row_d;
            col <= col_d;
        end
    end

    assign addr = addr_width'(row) * addr_width'(COLS) + addr_width'(col);

endmodule

// File: rtl/text_writer.sv
// Producer side of the character-cell text RAM: decodes a byte stream into RAM
// writes and cursor moves, and runs a space-fill clear sweep.
// Build option: TEXT_WRITER_CLEAR_ON_RESET_EN runs a full sweep after reset.
module text_writer
    import text_pkg::*;
#(
    parameter int addr_width = 7,
    parameter int data_width = 8,
    parameter int COLS       = 16,
    parameter int ROWS       = 5
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [data_width-1:0]      in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       clear,
    output logic                       write_en,
    output logic [addr_width-1:0]      waddr,
    output logic [data_width-1:0]      din,
    output logic [$clog2(ROWS)-1:0]    cursor_row,
    output logic [$clog2(COLS)-1:0]    cursor_col,
    output logic                       busy,
    output logic                       state_dbg
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(COLS * ROWS - 1);
    localparam logic [data_width-1:0] SPACE     = data_width'(CHAR_SPACE);

    state_e                  state_q, state_d;
    logic [addr_width-1:0]   sweep_q, sweep_d;
    logic                    wen_d;
    logic [addr_width-1:0]   waddr_d;
    logic [data_width-1:0]   din_d;
    cursor_op_e              cur_op;
    logic [addr_width-1:0]   cur_addr;
    logic                    init_req;
    logic                    accept;
    logic                    printable;

`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
    logic init_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            init_q <= 1'b1;
        end else if (state_q == CLEAR) begin
            init_q <= 1'b0;
        end
    end

    assign init_req = init_q;
`else
    assign init_req = 1'b0;
`endif

    // A byte transfers on a rising edge where in_valid && in_ready; in_valid may
    // be held across not-ready cycles and the byte is taken once ready rises.
    assign in_ready  = (state_q == IDLE) && !clear && !init_req;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == CLEAR);
    assign state_dbg = state_q;
    assign printable = (in_data >= data_width'(PRINT_LO)) &&
                       (in_data <= data_width'(PRINT_HI));

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        wen_d   = 1'b0;
        waddr_d = waddr;
        din_d   = din;
        cur_op  = OP_NONE;
        case (state_q)
            IDLE: begin
                if (clear || init_req ||
                    (accept && in_data == data_width'(CHAR_FF))) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                    cur_op  = OP_HOME;
                end else if (accept) begin
                    if (printable) begin
                        wen_d   = 1'b1;
                        waddr_d = cur_addr;
                        din_d   = in_data;
                        cur_op  = OP_INC;
                    end else if (in_data == data_width'(CHAR_CR)) begin
                        cur_op = OP_CR;
                    end else if (in_data == data_width'(CHAR_LF)) begin
                        cur_op = OP_NEWLINE;
                    end else if (in_data == data_width'(CHAR_BS) &&
                                 cursor_col != '0) begin
                        // Erase the cell the cursor moves back onto.
                        wen_d   = 1'b1;
                        waddr_d = cur_addr - addr_width'(1);
                        din_d   = SPACE;
                        cur_op  = OP_DEC;
                    end
                end
            end
            CLEAR: begin
                wen_d   = 1'b1;
                waddr_d = sweep_q;
                din_d   = SPACE;
                if (sweep_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    sweep_d = sweep_q + addr_width'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            sweep_q  <= '0;
            write_en <= 1'b0;
            waddr    <= '0;
            din      <= '0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            write_en <= wen_d;
            waddr    <= waddr_d;
            din      <= din_d;
        end
    end

    text_cursor #(
        .addr_width (addr_width),
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W)
    ) u_cursor (
        .clk  (clk),
        .rstn (rstn),
        .op   (cur_op),
        .row  (cursor_row),
        .col  (cursor_col),
        .addr (cur_addr)
    );

endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer: printable writes, wrap, control
// codes, clear sweeps and reset behaviour.
module tb_text_writer;

    logic       clk;
    logic       rstn;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       clear;
    logic       write_en;
    logic [6:0] waddr;
    logic [7:0] din;
    logic [2:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;
    logic       state_dbg;

    int checks;
    int errors;
    int cyc;

    logic [14:0] exp_q[$];
    logic [14:0] obs_q[$];
    int          obs_cyc_q[$];

    text_writer dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .clear      (clear),
        .write_en   (write_en),
        .waddr      (waddr),
        .din        (din),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor
    always @(negedge clk) begin
        if (rstn && write_en) begin
            obs_q.push_back({waddr, din});
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic flush_queues();
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
    endtask

    // Counts busy cycles of one sweep; gives up after a fixed cycle budget.
    task automatic wait_sweep(output int n);
        n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (busy) n++;
            else if (n > 0) break;
        end
    endtask

    task automatic compare_writes(input string name);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s write count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s write %0d: got addr %0d data %h expected addr %0d data %h",
                         name, i, obs_q[i][14:8], obs_q[i][7:0], exp_q[i][14:8], exp_q[i][7:0]);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00; clear = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({write_en, waddr, din} !== 16'h0000) begin
            errors++;
            $display("FAIL reset write port: got we %b addr %0d data %h expected 0 0 00", write_en, waddr, din);
        end
        checks++;
        if ({cursor_row, cursor_col, busy, state_dbg} !== 9'd0) begin
            errors++;
            $display("FAIL reset cursor/busy: got row %0d col %0d busy %b state %b expected 0 0 0 0",
                     cursor_row, cursor_col, busy, state_dbg);
        end
        @(negedge clk) rstn = 1'b1;
`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
        wait_sweep(n);
        checks++;
        if (n !== 80) begin
            errors++;
            $display("FAIL reset auto sweep: got %0d busy cycles expected 80", n);
        end
        idle(2);
`else
        #1;
`endif
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post-reset idle: got in_ready %b busy %b expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_print();
        flush_queues();
        send_byte(8'h41);
        send_byte(8'h42);
        idle(2);
        exp_q.push_back({7'd0, 8'h41});
        exp_q.push_back({7'd1, 8'h42});
        compare_writes("print");
        if (obs_cyc_q.size() == 2) begin
            checks++;
            if (obs_cyc_q[1] - obs_cyc_q[0] !== 1) begin
                errors++;
                $display("FAIL print back-to-back: got gap %0d expected 1", obs_cyc_q[1] - obs_cyc_q[0]);
            end
        end
        checks++;
        if (cursor_row !== 3'd0 || cursor_col !== 4'd2 || write_en !== 1'b0) begin
            errors++;
            $display("FAIL print cursor: got row %0d col %0d we %b expected 0 2 0", cursor_row, cursor_col, write_en);
        end
    endtask

    task automatic test_row_wrap();
        send_byte(8'h0D);
        idle(1);
        flush_queues();
        for (int i = 0; i < 15; i++) begin
            send_byte(8'h30);
            exp_q.push_back({7'(i), 8'h30});
        end
        send_byte(8'h31);
        exp_q.push_back({7'd15, 8'h31});
        idle(2);
        compare_writes("row_wrap");
        checks++;
        if (cursor_row !== 3'd1 || cursor_col !== 4'd0) begin
            errors++;
            $display("FAIL row_wrap cursor: got row %0d col %0d expected 1 0", cursor_row, cursor_col);
        end
        send_byte(8'h0A);
        idle(2);
        checks++;
        if (cursor_row !== 3'd2 || cursor_col !== 4'd0 || obs_q.size() !== 16) begin
            errors++;
            $display("FAIL linefeed: got row %0d col %0d writes %0d expected 2 0 16",
                     cursor_row, cursor_col, obs_q.size());
        end
    endtask

    task automatic test_screen_wrap();
        repeat (3) send_byte(8'h0A);
        idle(1);
        checks++;
        if (cursor_row !== 3'd0 || cursor_col !== 4'd0) begin
            errors++;
            $display("FAIL linefeed wrap: got row %0d col %0d expected 0 0", cursor_row, cursor_col);
        end
        flush_queues();
        for (int i = 0; i < 81; i++) begin
            send_byte(8'(8'h20 + i));
            exp_q.push_back({7'(i % 80), 8'(8'h20 + i)});
        end
        idle(2);
        compare_writes("screen_wrap");
        checks++;
        if (cursor_row !== 3'd0 || cursor_col !== 4'd1) begin
            errors++;
            $display("FAIL screen_wrap cursor: got row %0d col %0d expected 0 1", cursor_row, cursor_col);
        end
    endtask

    task automatic test_backspace();
        flush_queues();
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h08);
        idle(2);
        checks++;
        if (cursor_row !== 3'd0 || cursor_col !== 4'd2) begin
            errors++;
            $display("FAIL backspace cursor: got row %0d col %0d expected 0 2", cursor_row, cursor_col);
        end
        send_byte(8'h0D);
        send_byte(8'h08);
        idle(2);
        exp_q.push_back({7'd1, 8'h41});
        exp_q.push_back({7'd2, 8'h42});
        exp_q.push_back({7'd2, 8'h20});
        compare_writes("backspace");
        checks++;
        if (cursor_row !== 3'd0 || cursor_col !== 4'd0) begin
            errors++;
            $display("FAIL backspace at col0: got row %0d col %0d expected 0 0", cursor_row, cursor_col);
        end
    endtask

    task automatic test_ignored();
        flush_queues();
        send_byte(8'h41);
        send_byte(8'h00);
        send_byte(8'h7F);
        send_byte(8'hFF);
        send_byte(8'h1B);
        send_byte(8'h80);
        idle(2);
        exp_q.push_back({7'd0, 8'h41});
        compare_writes("ignored");
        checks++;
        if (cursor_row !== 3'd0 || cursor_col !== 4'd1) begin
            errors++;
            $display("FAIL ignored cursor: got row %0d col %0d expected 0 1", cursor_row, cursor_col);
        end
    endtask

    task automatic test_clear();
        int busy_cycles;
        logic got;
        flush_queues();
        in_data  = 8'h55;
        in_valid = 1'b1;
        clear    = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear wins over valid: got in_ready %b expected 0", in_ready);
        end
        @(posedge clk);
        #1 clear = 1'b0;
        busy_cycles = 0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                clear = (c == 40);
                if (c == 5) begin
                    checks++;
                    if (cursor_row !== 3'd0 || cursor_col !== 4'd0 || state_dbg !== 1'b1) begin
                        errors++;
                        $display("FAIL clear entry: got row %0d col %0d state %b expected 0 0 1",
                                 cursor_row, cursor_col, state_dbg);
                    end
                end
            end
        end
        clear = 1'b0;
        checks++;
        if (got !== 1'b1 || busy_cycles !== 80 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear sweep length: got ready %b busy cycles %0d busy %b expected 1 80 0",
                     got, busy_cycles, busy);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        idle(2);
        for (int i = 0; i < 80; i++) exp_q.push_back({7'(i), 8'h20});
        exp_q.push_back({7'd0, 8'h55});
        compare_writes("clear");
        checks++;
        if (cursor_row !== 3'd0 || cursor_col !== 4'd1) begin
            errors++;
            $display("FAIL clear then accept cursor: got row %0d col %0d expected 0 1", cursor_row, cursor_col);
        end
    endtask

    task automatic test_form_feed();
        int n;
        flush_queues();
        send_byte(8'h0C);
        wait_sweep(n);
        idle(2);
        checks++;
        if (n !== 80) begin
            errors++;
            $display("FAIL form feed sweep: got %0d busy cycles expected 80", n);
        end
        for (int i = 0; i < 80; i++) exp_q.push_back({7'(i), 8'h20});
        compare_writes("form_feed");
        checks++;
        if (cursor_row !== 3'd0 || cursor_col !== 4'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL form feed end: got row %0d col %0d ready %b expected 0 0 1",
                     cursor_row, cursor_col, in_ready);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        int writes_before;
        send_byte(8'h41);
        @(negedge clk) clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        repeat (10) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({write_en, waddr, din} !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid-sweep reset: got we %b addr %0d data %h busy %b expected 0 0 00 0",
                     write_en, waddr, din, busy);
        end
        checks++;
        if (cursor_row !== 3'd0 || cursor_col !== 4'd0 || state_dbg !== 1'b0) begin
            errors++;
            $display("FAIL mid-sweep reset state: got row %0d col %0d state %b expected 0 0 0",
                     cursor_row, cursor_col, state_dbg);
        end
        @(negedge clk) rstn = 1'b1;
        writes_before = obs_q.size();
`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
        wait_sweep(n);
        idle(2);
        checks++;
        if (n !== 80 || obs_q.size() - writes_before !== 80) begin
            errors++;
            $display("FAIL reset resweep: got %0d busy cycles %0d writes expected 80 80",
                     n, obs_q.size() - writes_before);
        end
`else
        n = 0;
        idle(4);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || obs_q.size() !== writes_before) begin
            errors++;
            $display("FAIL post-reset stays idle: got ready %b busy %b writes %0d expected 1 0 0",
                     in_ready, busy, obs_q.size() - writes_before);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_print();
        test_row_wrap();
        test_screen_wrap();
        test_backspace();
        test_ignored();
        test_clear();
        test_form_feed();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
